// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge
// AXI4-Lite slave that turns bus accesses into per-register byte-write
// strobes, read strobes and read-data capture for a register block.
// Write and read channels are independent FSMs, one transaction each.
// Optional feature macro: AXIL_REG_BRIDGE_SLVERR_EN
//   defined   -> out-of-range accesses answer SLVERR, reads return 32'hDEAD_BEEF
//   undefined -> out-of-range accesses answer OKAY, reads return 0,
//                writes are dropped
module axil_reg_bridge #(
  parameter int FPGA_REGISTER_N    = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 11
) (
  input  logic                                                    S_AXI_ACLK,
  input  logic                                                    S_AXI_ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                           S_AXI_AWADDR,
  input  logic [2:0]                                              S_AXI_AWPROT,
  input  logic                                                    S_AXI_AWVALID,
  output logic                                                    S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                           S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                         S_AXI_WSTRB,
  input  logic                                                    S_AXI_WVALID,
  output logic                                                    S_AXI_WREADY,
  // write response channel
  output logic [1:0]                                              S_AXI_BRESP,
  output logic                                                    S_AXI_BVALID,
  input  logic                                                    S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                           S_AXI_ARADDR,
  input  logic [2:0]                                              S_AXI_ARPROT,
  input  logic                                                    S_AXI_ARVALID,
  output logic                                                    S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]                           S_AXI_RDATA,
  output logic [1:0]                                              S_AXI_RRESP,
  output logic                                                    S_AXI_RVALID,
  input  logic                                                    S_AXI_RREADY,
  // register block side
  output logic [C_S_AXI_DATA_WIDTH-1:0]                           reg_wrdout,
  output logic [FPGA_REGISTER_N-1:0][C_S_AXI_DATA_WIDTH/8-1:0]    reg_wrByteStrobe,
  output logic [FPGA_REGISTER_N-1:0]                              reg_rdStrobe,
  input  logic [FPGA_REGISTER_N-1:0][C_S_AXI_DATA_WIDTH-1:0]      reg_rddin
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_BRIDGE_SLVERR_EN
  localparam logic [1:0]                    OOR_RESP  = 2'b10;
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] OOR_RDATA = C_S_AXI_DATA_WIDTH'(32'hDEAD_BEEF);
`else
  localparam logic [1:0]                    OOR_RESP  = 2'b00;
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] OOR_RDATA = C_S_AXI_DATA_WIDTH'(32'h0000_0000);
`endif

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_STROBE = 2'd1,
    W_RESP   = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_STROBE = 2'd1,
    R_DATA   = 2'd2
  } r_state_t;

  // True when a word index addresses an implemented register.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (int'(idx) < FPGA_REGISTER_N);
  endfunction

  // ------------------------------------------------------------------
  // Reset: asserts asynchronously, releases synchronously to the clock
  // ------------------------------------------------------------------
  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Two-flop reset-release synchroniser.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ------------------------------------------------------------------
  // Write channel
  // ------------------------------------------------------------------
  w_state_t                                w_state_r, w_state_s;
  logic                                    aw_held_r, aw_held_s;
  logic                                    w_held_r, w_held_s;
  logic [IDX_W-1:0]                        aw_idx_r, aw_idx_s;
  logic [C_S_AXI_DATA_WIDTH-1:0]           wdata_r, wdata_s;
  logic [STRB_W-1:0]                       wstrb_r, wstrb_s;
  logic                                    awready_r, awready_s;
  logic                                    wready_r, wready_s;
  logic                                    bvalid_r, bvalid_s;
  logic [1:0]                              bresp_r, bresp_s;
  logic [C_S_AXI_DATA_WIDTH-1:0]           wrdout_r, wrdout_s;
  logic [FPGA_REGISTER_N-1:0][STRB_W-1:0]  wr_strobe_r, wr_strobe_s;
  logic                                    aw_hs_s, w_hs_s;

  // Write FSM next state, capture of AW/W and next values of all write outputs.
  always_comb begin
    w_state_s   = w_state_r;
    aw_held_s   = aw_held_r;
    w_held_s    = w_held_r;
    aw_idx_s    = aw_idx_r;
    wdata_s     = wdata_r;
    wstrb_s     = wstrb_r;
    awready_s   = awready_r;
    wready_s    = wready_r;
    bvalid_s    = bvalid_r;
    bresp_s     = bresp_r;
    wrdout_s    = wrdout_r;
    wr_strobe_s = '0;
    aw_hs_s     = S_AXI_AWVALID && awready_r;
    w_hs_s      = S_AXI_WVALID && wready_r;

    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_held_s = 1'b1;
          aw_idx_s  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else begin
          aw_held_s = aw_held_r;
        end
        if (w_hs_s) begin
          w_held_s = 1'b1;
          wdata_s  = S_AXI_WDATA;
          wstrb_s  = S_AXI_WSTRB;
        end else begin
          w_held_s = w_held_r;
        end
        if (aw_held_s && w_held_s) begin
          // Both halves present: fire the byte strobes next cycle.
          w_state_s = W_STROBE;
          aw_held_s = 1'b0;
          w_held_s  = 1'b0;
          awready_s = 1'b0;
          wready_s  = 1'b0;
          wrdout_s  = wdata_s;
          for (int i = 0; i < FPGA_REGISTER_N; i++) begin
            if (aw_idx_s == IDX_W'(i)) begin
              wr_strobe_s[i] = wstrb_s;
            end else begin
              wr_strobe_s[i] = {STRB_W{1'b0}};
            end
          end
        end else begin
          awready_s = !aw_held_s;
          wready_s  = !w_held_s;
        end
      end
      W_STROBE: begin
        w_state_s = W_RESP;
        bvalid_s  = 1'b1;
        if (idx_in_range(aw_idx_r)) begin
          bresp_s = RESP_OKAY;
        end else begin
          bresp_s = OOR_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY && bvalid_r) begin
          w_state_s = W_IDLE;
          bvalid_s  = 1'b0;
          bresp_s   = RESP_OKAY;
          awready_s = 1'b1;
          wready_s  = 1'b1;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: begin
        w_state_s = W_IDLE;
        aw_held_s = 1'b0;
        w_held_s  = 1'b0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
        bresp_s   = RESP_OKAY;
      end
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      w_state_r <= W_IDLE;
    end else begin
      w_state_r <= w_state_s;
    end
  end

  // Write channel capture and registered outputs.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      aw_held_r   <= 1'b0;
      w_held_r    <= 1'b0;
      aw_idx_r    <= {IDX_W{1'b0}};
      wdata_r     <= {C_S_AXI_DATA_WIDTH{1'b0}};
      wstrb_r     <= {STRB_W{1'b0}};
      awready_r   <= 1'b0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      wrdout_r    <= {C_S_AXI_DATA_WIDTH{1'b0}};
      wr_strobe_r <= '0;
    end else begin
      aw_held_r   <= aw_held_s;
      w_held_r    <= w_held_s;
      aw_idx_r    <= aw_idx_s;
      wdata_r     <= wdata_s;
      wstrb_r     <= wstrb_s;
      awready_r   <= awready_s;
      wready_r    <= wready_s;
      bvalid_r    <= bvalid_s;
      bresp_r     <= bresp_s;
      wrdout_r    <= wrdout_s;
      wr_strobe_r <= wr_strobe_s;
    end
  end

  // ------------------------------------------------------------------
  // Read channel
  // ------------------------------------------------------------------
  r_state_t                      r_state_r, r_state_s;
  logic [IDX_W-1:0]              ar_idx_r, ar_idx_s;
  logic                          arready_r, arready_s;
  logic                          rvalid_r, rvalid_s;
  logic [1:0]                    rresp_r, rresp_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r, rdata_s;
  logic [FPGA_REGISTER_N-1:0]    rd_strobe_r, rd_strobe_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux_s;

  // Selects the read value of the register latched for the current read.
  always_comb begin
    rd_mux_s = {C_S_AXI_DATA_WIDTH{1'b0}};
    for (int i = 0; i < FPGA_REGISTER_N; i++) begin
      if (ar_idx_r == IDX_W'(i)) begin
        rd_mux_s = reg_rddin[i];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
  end

  // Read FSM next state and next values of all read outputs.
  always_comb begin
    r_state_s   = r_state_r;
    ar_idx_s    = ar_idx_r;
    arready_s   = arready_r;
    rvalid_s    = rvalid_r;
    rresp_s     = rresp_r;
    rdata_s     = rdata_r;
    rd_strobe_s = {FPGA_REGISTER_N{1'b0}};

    case (r_state_r)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_r) begin
          r_state_s = R_STROBE;
          ar_idx_s  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
          arready_s = 1'b0;
          for (int i = 0; i < FPGA_REGISTER_N; i++) begin
            rd_strobe_s[i] = (ar_idx_s == IDX_W'(i));
          end
        end else begin
          arready_s = 1'b1;
        end
      end
      R_STROBE: begin
        // Capture the register value presented during the strobe cycle.
        r_state_s = R_DATA;
        rvalid_s  = 1'b1;
        if (idx_in_range(ar_idx_r)) begin
          rdata_s = rd_mux_s;
          rresp_s = RESP_OKAY;
        end else begin
          rdata_s = OOR_RDATA;
          rresp_s = OOR_RESP;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY && rvalid_r) begin
          r_state_s = R_IDLE;
          rvalid_s  = 1'b0;
          rresp_s   = RESP_OKAY;
          arready_s = 1'b1;
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: begin
        r_state_s = R_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
        rresp_s   = RESP_OKAY;
      end
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      r_state_r <= R_IDLE;
    end else begin
      r_state_r <= r_state_s;
    end
  end

  // Read channel capture and registered outputs.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ar_idx_r    <= {IDX_W{1'b0}};
      arready_r   <= 1'b0;
      rvalid_r    <= 1'b0;
      rresp_r     <= 2'b00;
      rdata_r     <= {C_S_AXI_DATA_WIDTH{1'b0}};
      rd_strobe_r <= {FPGA_REGISTER_N{1'b0}};
    end else begin
      ar_idx_r    <= ar_idx_s;
      arready_r   <= arready_s;
      rvalid_r    <= rvalid_s;
      rresp_r     <= rresp_s;
      rdata_r     <= rdata_s;
      rd_strobe_r <= rd_strobe_s;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign S_AXI_AWREADY    = awready_r;
  assign S_AXI_WREADY     = wready_r;
  assign S_AXI_BVALID     = bvalid_r;
  assign S_AXI_BRESP      = bresp_r;
  assign S_AXI_ARREADY    = arready_r;
  assign S_AXI_RVALID     = rvalid_r;
  assign S_AXI_RRESP      = rresp_r;
  assign S_AXI_RDATA      = rdata_r;
  assign reg_wrdout       = wrdout_r;
  assign reg_wrByteStrobe = wr_strobe_r;
  assign reg_rdStrobe     = rd_strobe_r;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// Self-checking bench for axil_reg_bridge: directed scenarios followed by
// randomized single transactions checked against an address-decode model.
module tb_axil_reg_bridge;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int AW = 11;

`ifdef AXIL_REG_BRIDGE_SLVERR_EN
  localparam logic [1:0]  EXP_OOR_RESP = 2'b10;
  localparam logic [31:0] EXP_OOR_DATA = 32'hDEAD_BEEF;
`else
  localparam logic [1:0]  EXP_OOR_RESP = 2'b00;
  localparam logic [31:0] EXP_OOR_DATA = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = 3'd0, arprot = 3'd0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = 4'h0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata, wrdout;
  logic [N-1:0][3:0] wr_strobe;
  logic [N-1:0] rd_strobe;
  logic [N-1:0][DW-1:0] rddin = '0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  axil_reg_bridge #(.FPGA_REGISTER_N(N), .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_wrdout(wrdout), .reg_wrByteStrobe(wr_strobe), .reg_rdStrobe(rd_strobe), .reg_rddin(rddin)
  );

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts every cycle in which a register strobe is high.
  int wr_cnt[N] = '{default: 0};
  int rd_cnt[N] = '{default: 0};
  int wr_cyc[N] = '{default: -1};
  int rd_cyc[N] = '{default: -1};
  logic [3:0] wr_strb_seen[N] = '{default: 4'h0};
  logic [31:0] wr_data_seen[N] = '{default: 32'h0};
  int wr_total = 0;
  int rd_total = 0;

  always @(negedge clk) begin
    int nw;
    int nr;
    nw = 0;
    nr = 0;
    for (int i = 0; i < N; i++) begin
      if (wr_strobe[i] != 4'h0) begin
        wr_cnt[i] <= wr_cnt[i] + 1;
        wr_cyc[i] <= cyc;
        wr_strb_seen[i] <= wr_strobe[i];
        wr_data_seen[i] <= wrdout;
        nw++;
      end
      if (rd_strobe[i]) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        rd_cyc[i] <= cyc;
        nr++;
      end
    end
    wr_total <= wr_total + nw;
    rd_total <= rd_total + nr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives AW and W; w_lead > 0 presents W that many cycles before AW, < 0 AW first.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, output int hs_cyc);
    logic aw_pend, w_pend, aw_hs, w_hs;
    int t;
    aw_pend = 1'b1;
    w_pend = 1'b1;
    t = 0;
    hs_cyc = -1;
    awaddr = addr;
    wdata = data;
    wstrb = strb;
    while ((aw_pend || w_pend) && t < 40) begin
      awvalid = aw_pend && (t >= ((w_lead > 0) ? w_lead : 0));
      wvalid = w_pend && (t >= ((w_lead < 0) ? -w_lead : 0));
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      step();
      t++;
      if (aw_hs) aw_pend = 1'b0;
      if (w_hs) w_pend = 1'b0;
      if (aw_hs || w_hs) hs_cyc = cyc;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("write_handshake_done", {62'd0, aw_pend, w_pend}, 64'd0);
  endtask

  // Waits for BVALID, holds BREADY low for 'hold' cycles, then accepts the response.
  task automatic wait_b(input int hold, input logic [1:0] exp_resp, output int bv_cyc);
    int t;
    t = 0;
    bready = 1'b0;
    while (!bvalid && t < 40) begin
      step();
      t++;
    end
    bv_cyc = cyc;
    check("bvalid_seen", {63'd0, bvalid}, 64'd1);
    check("bresp", {62'd0, bresp}, {62'd0, exp_resp});
    for (int h = 0; h < hold; h++) begin
      step();
      check("bvalid_held", {63'd0, bvalid}, 64'd1);
      check("awready_low_in_resp", {62'd0, awready, wready}, 64'd0);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("bvalid_dropped", {63'd0, bvalid}, 64'd0);
  endtask

  // Full read; RDATA/RRESP checked on every cycle RVALID is held.
  task automatic axi_read(input logic [AW-1:0] addr, input int hold, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, output int ar_cyc, output int rv_cyc);
    logic hs;
    int t;
    araddr = addr;
    arvalid = 1'b1;
    rready = 1'b0;
    hs = 1'b0;
    t = 0;
    while (!hs && t < 40) begin
      hs = arready;
      step();
      t++;
    end
    arvalid = 1'b0;
    ar_cyc = cyc;
    check("ar_handshake", {63'd0, hs}, 64'd1);
    t = 0;
    while (!rvalid && t < 40) begin
      step();
      t++;
    end
    rv_cyc = cyc;
    check("rvalid_seen", {63'd0, rvalid}, 64'd1);
    check("rdata", {32'd0, rdata}, {32'd0, exp_data});
    check("rresp", {62'd0, rresp}, {62'd0, exp_resp});
    for (int h = 0; h < hold; h++) begin
      step();
      check("rdata_stable", {32'd0, rdata}, {32'd0, exp_data});
      check("rvalid_held_arready_low", {62'd0, rvalid, arready}, 64'd2);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("rvalid_dropped", {63'd0, rvalid}, 64'd0);
  endtask

  initial begin
    int hs, bv, ar, rv, t, w0, r0, c0, c1, idx, lead, hold;
    logic [31:0] d, exp_d;
    logic [3:0] s;
    logic [AW-1:0] a;
    logic [8:0] idx9;
    logic [1:0] lo;
    logic in_rng;
    logic [31:0] bv_first, rv_first, rd_got;
    logic [1:0] br_got, rr_got;

    // ---- reset state ----
    repeat (3) step();
    check("rst_readies", {61'd0, awready, wready, arready}, 64'd0);
    check("rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
    check("rst_wrdout", {32'd0, wrdout}, 64'd0);
    check("rst_strobes", {48'd0, wr_strobe}, 64'd0);
    check("rst_rdstrobes", {48'd0, rd_strobe}, 64'd0);
    rst_n = 1'b1;
    repeat (5) step();
    check("idle_readies", {61'd0, awready, wready, arready}, 64'd7);

    // ---- AW and W together, idx 2 ----
    w0 = wr_total;
    c0 = wr_cnt[2];
    axi_write(11'h008, 32'hA5A5_0001, 4'hF, 0, hs);
    wait_b(0, 2'b00, bv);
    check("t1_bvalid_latency", bv, hs + 1);
    check("t1_pulse_count", wr_cnt[2] - c0, 1);
    check("t1_total_pulses", wr_total - w0, 1);
    check("t1_strobe_cycle", wr_cyc[2], hs);
    check("t1_strobe_value", {60'd0, wr_strb_seen[2]}, 64'hF);
    check("t1_wrdout", {32'd0, wr_data_seen[2]}, 64'hA5A5_0001);

    // ---- W two cycles before AW, idx 3, WSTRB 3 ----
    w0 = wr_total;
    c0 = wr_cnt[3];
    axi_write(11'h00C, 32'h0BAD_F00D, 4'h3, 2, hs);
    wait_b(2, 2'b00, bv);
    check("t2_bvalid_latency", bv, hs + 1);
    check("t2_pulse_count", wr_cnt[3] - c0, 1);
    check("t2_total_pulses", wr_total - w0, 1);
    check("t2_strobe_value", {60'd0, wr_strb_seen[3]}, 64'h3);
    check("t2_wrdout", {32'd0, wr_data_seen[3]}, 64'h0BAD_F00D);

    // ---- read idx 1 with RREADY held low 5 cycles ----
    rddin[1] = 32'h1234_5678;
    r0 = rd_total;
    c0 = rd_cnt[1];
    axi_read(11'h004, 5, 32'h1234_5678, 2'b00, ar, rv);
    check("t3_rvalid_latency", rv, ar + 1);
    check("t3_pulse_count", rd_cnt[1] - c0, 1);
    check("t3_total_pulses", rd_total - r0, 1);
    check("t3_strobe_cycle", rd_cyc[1], ar);

    // ---- out-of-range read and write ----
    r0 = rd_total;
    axi_read(11'h3FC, 1, EXP_OOR_DATA, EXP_OOR_RESP, ar, rv);
    check("oor_read_no_strobe", rd_total - r0, 0);
    w0 = wr_total;
    axi_write(11'h7F0, 32'hFFFF_FFFF, 4'hF, 0, hs);
    wait_b(1, EXP_OOR_RESP, bv);
    check("oor_write_no_strobe", wr_total - w0, 0);

    // ---- concurrent write and read of idx 5 ----
    rddin[5] = 32'hC0DE_0005;
    c0 = wr_cnt[5];
    c1 = rd_cnt[5];
    check("conc_readies", {61'd0, awready, wready, arready}, 64'd7);
    awaddr = 11'h014;
    araddr = 11'h014;
    wdata = 32'h5555_AAAA;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    arvalid = 1'b1;
    step();
    hs = cyc;
    awvalid = 1'b0;
    wvalid = 1'b0;
    arvalid = 1'b0;
    bready = 1'b1;
    rready = 1'b1;
    bv = -1;
    rv = -1;
    t = 0;
    br_got = 2'b11;
    rr_got = 2'b11;
    rd_got = 32'h0;
    while ((bv < 0 || rv < 0) && t < 20) begin
      if (bvalid && bv < 0) begin bv = cyc; br_got = bresp; end
      if (rvalid && rv < 0) begin rv = cyc; rr_got = rresp; rd_got = rdata; end
      step();
      t++;
    end
    bready = 1'b0;
    rready = 1'b0;
    check("conc_wr_strobe_cycle", wr_cyc[5], hs);
    check("conc_rd_strobe_cycle", rd_cyc[5], hs);
    check("conc_wr_pulses", wr_cnt[5] - c0, 1);
    check("conc_rd_pulses", rd_cnt[5] - c1, 1);
    check("conc_bvalid_cycle", bv, hs + 1);
    check("conc_rvalid_cycle", rv, hs + 1);
    check("conc_bresp", {62'd0, br_got}, 64'd0);
    check("conc_rresp", {62'd0, rr_got}, 64'd0);
    check("conc_rdata", {32'd0, rd_got}, 64'hC0DE_0005);

    // ---- reset while BVALID is high ----
    axi_write(11'h020, 32'h1111_2222, 4'hF, 0, hs);
    t = 0;
    while (!bvalid && t < 10) begin
      step();
      t++;
    end
    check("rst_mid_bvalid_seen", {63'd0, bvalid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_bvalid_async_drop", {63'd0, bvalid}, 64'd0);
    check("rst_mid_readies", {61'd0, awready, wready, arready}, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_no_bvalid", {63'd0, bvalid}, 64'd0);
    check("post_rst_readies", {61'd0, awready, wready, arready}, 64'd7);
    w0 = wr_total;
    c0 = wr_cnt[6];
    axi_write(11'h018, 32'h6666_0006, 4'hC, -1, hs);
    wait_b(0, 2'b00, bv);
    check("post_rst_pulses", wr_cnt[6] - c0, 1);
    check("post_rst_total", wr_total - w0, 1);
    check("post_rst_strobe", {60'd0, wr_strb_seen[6]}, 64'hC);
    check("post_rst_bvalid_latency", bv, hs + 1);

    // ---- randomized transactions against the decode model ----
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) rddin[i] = $urandom;
      if ($urandom_range(0, 3) == 0) idx = $urandom_range(N, 511);
      else idx = $urandom_range(0, N - 1);
      idx9 = idx[8:0];
      lo = 2'($urandom_range(0, 3));
      a = {idx9, lo};
      in_rng = (idx < N);
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        lead = $urandom_range(0, 4) - 2;
        w0 = wr_total;
        c0 = in_rng ? wr_cnt[idx] : 0;
        axi_write(a, d, s, lead, hs);
        wait_b(hold, in_rng ? 2'b00 : EXP_OOR_RESP, bv);
        check("rnd_w_bvalid_latency", bv, hs + 1);
        check("rnd_w_total", wr_total - w0, (in_rng && s != 4'h0) ? 1 : 0);
        if (in_rng && s != 4'h0) begin
          check("rnd_w_pulse", wr_cnt[idx] - c0, 1);
          check("rnd_w_strb", {60'd0, wr_strb_seen[idx]}, {60'd0, s});
          check("rnd_w_data", {32'd0, wr_data_seen[idx]}, {32'd0, d});
        end
      end else begin
        exp_d = in_rng ? rddin[idx] : EXP_OOR_DATA;
        r0 = rd_total;
        axi_read(a, hold, exp_d, in_rng ? 2'b00 : EXP_OOR_RESP, ar, rv);
        check("rnd_r_rvalid_latency", rv, ar + 1);
        check("rnd_r_total", rd_total - r0, in_rng ? 1 : 0);
        if (in_rng) check("rnd_r_strobe_cycle", rd_cyc[idx], ar);
      end
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
- AXI4-Lite slave that converts bus transactions into per-register write byte-strobes, read strobes and read-data capture.
- Sits directly upstream of every myModule_interface register block and drives its reg_wrdout / reg_wrByteStrobe / reg_rdStrobe / reg_rddin bundle.
- Write and read channels run as independent state machines. One outstanding transaction per channel.

Parameters:
- FPGA_REGISTER_N, 16, number of 32-bit word registers decoded (1..2^(C_S_AXI_ADDR_WIDTH-2))
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 11, AXI byte-address width

Ports:
- S_AXI_ACLK  in  1  single clock
- S_AXI_ARESETN  in  1  reset, asynchronous and active-low
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  standard AXI4-Lite write channels; AWPROT ignored
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite read channels; ARPROT ignored
- reg_wrdout  out  C_S_AXI_DATA_WIDTH  write data, shared by all registers
- reg_wrByteStrobe  out  [N-1:0] x DATA_WIDTH/8  per-register byte-write pulse
- reg_rdStrobe  out  [N-1:0] x 1  per-register read pulse (for clear-on-read / FIFO pop)
- reg_rddin  in  [N-1:0] x DATA_WIDTH  per-register read value

Behaviour:
- Reset: all AXI outputs, reg_wrdout, every strobe and both FSMs go to 0 / IDLE. Takes effect immediately (async); deassertion is synchronised internally with a 2-flop synchroniser. In-flight transactions are dropped and produce no response.
- Register index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]. ADDR[1:0] is ignored. Index >= FPGA_REGISTER_N is out of range.
- Write FSM states: W_IDLE, W_STROBE, W_RESP.
  - W_IDLE: AWREADY=1 until AW is latched; WREADY=1 until W is latched.
  - AW and W may arrive in either order or in the same cycle; each is captured independently.
  - When both are held, go to W_STROBE.
- W_STROBE (one cycle):
  - reg_wrdout=WDATA.
  - reg_wrByteStrobe[idx]=WSTRB; all other registers' strobes are 0.
  - Out of range: no strobe asserted.
  - WSTRB=0: strobe stays 0, but the transaction still completes.
- W_RESP: BVALID=1 with BRESP=OKAY (00) until BREADY; then return to W_IDLE. AWREADY and WREADY stay 0 until then.
- Write latency: last of AW/W handshake at edge k -> strobe in cycle k+1 -> BVALID from cycle k+2.
- Read FSM states: R_IDLE, R_STROBE, R_DATA.
  - R_IDLE: ARREADY=1. On handshake, latch the index and go to R_STROBE.
  - R_STROBE (one cycle): reg_rdStrobe[idx]=1 (none if out of range). At the end of the cycle, RDATA <= reg_rddin[idx] (0 if out of range).
  - R_DATA: RVALID=1, RRESP=OKAY; RDATA held stable until RREADY, then return to R_IDLE.
- Read latency: AR handshake at edge k -> rdStrobe in cycle k+1 -> RVALID from cycle k+2.
- All strobes are registered, single-cycle pulses; never asserted for more than one cycle per transaction.
- Simultaneous read and write, including to the same index: both proceed. The read captures reg_rddin as presented in R_STROBE, so ordering is the register block's concern.
- BREADY/RREADY held low indefinitely: the respective channel stalls and the other channel is unaffected.

Optional Feature:
- Macro AXIL_REG_BRIDGE_SLVERR_EN.
- Defined: out-of-range accesses return BRESP/RRESP = SLVERR (2'b10). Read data = 32'hDEAD_BEEF. No strobes asserted.
- Undefined: out-of-range accesses return OKAY. Reads return 0 and writes are silently dropped.

Test Plan:
- AW and W in the same cycle, addr 0x008, data 0xA5A5_0001, WSTRB 0xF -> reg_wrByteStrobe[2]=4'hF for exactly one cycle with reg_wrdout=0xA5A5_0001; BVALID two cycles after the handshake, BRESP=00.
- W two cycles before AW, addr 0x00C, WSTRB 0x3 -> single pulse reg_wrByteStrobe[3]=4'h3; no other strobe asserted; one B response.
- Read addr 0x004 with reg_rddin[1]=0x1234_5678 and RREADY held low 5 cycles -> one reg_rdStrobe[1] pulse; RVALID from cycle k+2 with RDATA stable at 0x1234_5678 until RREADY; ARREADY=0 meanwhile.
- Read addr 0x3FC with N=16 -> no strobes. With the macro: RRESP=10, RDATA=0xDEADBEEF. Without the macro: RRESP=00, RDATA=0.
- Concurrent write to idx 5 and read of idx 5 in the same cycle -> both strobes fire in cycle k+1; both responses complete independently.
- ARESETN asserted while BVALID=1 -> BVALID drops immediately with no clock edge; after release, a new write completes normally with a single strobe.
